serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fulladder.sv | 27 ++
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Per-bit arithmetic core: full adder assembled from two half adders and an OR.
module halfadder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1_s;
    logic c1_s;
    logic c2_s;

    halfadder u_ha0 (.a(a),    .b(b),   .sum(s1_s), .cout(c1_s));
    halfadder u_ha1 (.a(s1_s), .b(cin), .sum(sum),  .cout(c2_s));

    assign cout = c1_s | c2_s;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock with start/done handshake.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] r_r;
    logic             c_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;

    logic             bit_s;
    logic             cout_s;
    logic [WIDTH-1:0] r_next_s;
    logic [WIDTH-1:0] sb_load_s;
    logic             c_load_s;

    fulladder u_fa (
        .a    (sa_r[0]),
        .b    (sb_r[0]),
        .cin  (c_r),
        .sum  (bit_s),
        .cout (cout_s)
    );

    // New bit enters the result from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    assign r_next_s = WIDTH'({bit_s, r_r} >> 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    assign sb_load_s = sub ? ~b : b;
    assign c_load_s  = sub;
`else
    assign sb_load_s = b;
    assign c_load_s  = 1'b0;
`endif

    // Control FSM, operand/result shifting and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            sa_r    <= '0;
            sb_r    <= '0;
            r_r     <= '0;
            c_r     <= 1'b0;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        sa_r    <= a;
                        sb_r    <= sb_load_s;
                        c_r     <= c_load_s;
                        count_r <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa_r <= sa_r >> 1'b1;
                    sb_r <= sb_r >> 1'b1;
                    c_r  <= cout_s;
                    r_r  <= r_next_s;
                    if (count_r == LAST) begin
                        sum_r   <= r_next_s;
                        carry_r <= cout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign carry = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations vs an arithmetic model.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] prev_sum;
    logic         prev_carry;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; glitch = k>0 pulses start (with junk operands) before the k-th edge after acceptance.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsub, input int glitch);
        logic [W:0]   wide;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
        if (tsub) begin
            exp_sum   = ta - tb_;
            exp_carry = (ta >= tb_);
        end else begin
            wide      = {1'b0, ta} + {1'b0, tb_};
            exp_sum   = wide[W-1:0];
            exp_carry = wide[W];
        end
        a = ta;
        b = tb_;
        sub = tsub;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = ~tsub;
        for (int k = 1; k <= W + 1; k++) begin
            if (k == glitch) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            if (k < W) begin
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_nodone", 32'(done), 32'd0);
                chk("run_sum_held", 32'(sum), 32'(prev_sum));
                chk("run_carry_held", 32'(carry), 32'(prev_carry));
            end else if (k == W) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy", 32'(busy), 32'd0);
                chk("sum", 32'(sum), 32'(exp_sum));
                chk("carry", 32'(carry), 32'(exp_carry));
            end else begin
                chk("post_done_low", 32'(done), 32'd0);
                chk("post_busy_low", 32'(busy), 32'd0);
                chk("post_sum_held", 32'(sum), 32'(exp_sum));
            end
        end
        start = 1'b0;
        prev_sum = exp_sum;
        prev_carry = exp_carry;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        prev_sum = '0;
        prev_carry = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_carry", 32'(carry), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_sum", 32'(sum), 32'd0);
            chk("idle_carry", 32'(carry), 32'd0);
        end

        // Directed additions
        run_op(8'h0F, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b0, 0);
        // Start pulsed in RUN and in DONE is ignored
        run_op(8'h03, 8'h04, 1'b0, 3);
        run_op(8'h03, 8'h04, 1'b0, W + 1);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            chk("no_extra_done", 32'(done), 32'd0);
        end

        // Reset during RUN cycle 4
        a = 8'h55;
        b = 8'h66;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_run_busy", 32'(busy), 32'd0);
        chk("rst_run_done", 32'(done), 32'd0);
        chk("rst_run_sum", 32'(sum), 32'd0);
        chk("rst_run_carry", 32'(carry), 32'd0);
        prev_sum = '0;
        prev_carry = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            chk("rst_run_no_done", 32'(done), 32'd0);
            chk("rst_run_idle", 32'(busy), 32'd0);
        end
        run_op(8'h80, 8'h80, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h07, 8'h05, 1'b1, 0);
        run_op(8'h05, 8'h07, 1'b1, 0);
        run_op(8'h0F, 8'h01, 1'b0, 0);
`endif

        // Randomized operations, including stray start pulses
        for (int i = 0; i < 30; i++) begin
            logic ts;
`ifdef SERIAL_ADDER_SUB_EN
            ts = 1'($urandom_range(0, 1));
`else
            ts = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), ts, int'($urandom_range(0, W + 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
